uart_rx_fsm: RTL

- Receive-path controller for the UART RX.
- Detects the start-bit falling edge, runs the oversampling edge and bit counters, and enables the data sampler, start check, parity check, stop check and deserializer in frame order.
- Collects glitch, parity and stop errors and issues a one-cycle data-valid strobe for each good frame.
- Sits between the RX_IN pin and the RX check and deserializer blocks.

---
 rtl/uart_rx_fsm.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/uart_rx_fsm.sv
// UART receive-path controller: tracks the frame bit by bit on the oversampling clock,
// enables the per-bit checkers in order and reports one good-frame or frame-error strobe.
module uart_rx_fsm #(
  parameter int DATA_WIDTH  = 8,
  parameter int PRESC_WIDTH = 6
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   RX_IN,
  input  logic [PRESC_WIDTH-1:0] Prescale,
  input  logic                   PAR_EN,
  input  logic                   Sample_Valid,
  input  logic                   StrtChk_glitch,
  input  logic                   ParChk_err,
  input  logic                   StpChk_err,
  output logic [PRESC_WIDTH-1:0] Edge_Cnt,
  output logic [3:0]             Bit_Cnt,
  output logic                   DatSamp_EN,
  output logic                   StrtChk_EN,
  output logic                   ParChk_EN,
  output logic                   StpChk_EN,
  output logic                   Deser_EN,
  output logic                   Data_Valid,
  output logic                   Frame_Err
);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  localparam logic [PRESC_WIDTH-1:0] PRESC_ONE = PRESC_WIDTH'(1);
  localparam logic [3:0]             LAST_BIT  = 4'(DATA_WIDTH - 1);

  state_t                   state, state_nxt;
  logic [PRESC_WIDTH-1:0]   presc_lat, presc_nxt, edge_nxt;
  logic                     par_en_lat, par_en_nxt;
  logic                     par_err, par_err_nxt;
  logic [3:0]               bit_nxt;
  logic                     deser_nxt, dv_nxt, fe_nxt;
  logic                     bit_end;

  assign bit_end = (Edge_Cnt == (presc_lat - PRESC_ONE));

  always_comb begin
    state_nxt   = state;
    presc_nxt   = presc_lat;
    par_en_nxt  = par_en_lat;
    par_err_nxt = par_err;
    bit_nxt     = Bit_Cnt;
    edge_nxt    = '0;
    deser_nxt   = 1'b0;
    dv_nxt      = 1'b0;
    fe_nxt      = 1'b0;

    if (state != IDLE) begin
      edge_nxt = bit_end ? '0 : (Edge_Cnt + PRESC_ONE);
    end

    case (state)
      IDLE: begin
        bit_nxt = '0;
        if (!RX_IN) begin
          state_nxt   = START;
          presc_nxt   = Prescale;
          par_en_nxt  = PAR_EN;
          par_err_nxt = 1'b0;
        end
      end
      START: begin
        if (Sample_Valid && StrtChk_glitch) begin
          state_nxt = IDLE;
          edge_nxt  = '0;
          bit_nxt   = '0;
        end else if (bit_end) begin
          state_nxt = DATA;
          bit_nxt   = '0;
        end
      end
      DATA: begin
        deser_nxt = Sample_Valid;
        if (bit_end) begin
          if (Bit_Cnt == LAST_BIT) begin
            state_nxt = par_en_lat ? PARITY : STOP;
            bit_nxt   = '0;
          end else begin
            bit_nxt = Bit_Cnt + 4'd1;
          end
        end
      end
      PARITY: begin
        if (Sample_Valid && ParChk_err) begin
          par_err_nxt = 1'b1;
        end
        if (bit_end) begin
          state_nxt = STOP;
        end
      end
      STOP: begin
        // Leave at mid stop bit so a back-to-back start edge is not missed.
        if (Sample_Valid) begin
          if (!StpChk_err && !par_err) begin
            dv_nxt = 1'b1;
          end else begin
            fe_nxt = 1'b1;
          end
          state_nxt = IDLE;
          edge_nxt  = '0;
        end else if (bit_end) begin
          fe_nxt    = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
        edge_nxt  = '0;
        bit_nxt   = '0;
      end
    endcase
  end

  // Enables are registered from the next state so they line up with the state register.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state      <= IDLE;
      presc_lat  <= '0;
      par_en_lat <= 1'b0;
      par_err    <= 1'b0;
      Edge_Cnt   <= '0;
      Bit_Cnt    <= '0;
      DatSamp_EN <= 1'b0;
      StrtChk_EN <= 1'b0;
      ParChk_EN  <= 1'b0;
      StpChk_EN  <= 1'b0;
      Deser_EN   <= 1'b0;
      Data_Valid <= 1'b0;
      Frame_Err  <= 1'b0;
    end else begin
      state      <= state_nxt;
      presc_lat  <= presc_nxt;
      par_en_lat <= par_en_nxt;
      par_err    <= par_err_nxt;
      Edge_Cnt   <= edge_nxt;
      Bit_Cnt    <= bit_nxt;
      DatSamp_EN <= (state_nxt != IDLE);
      StrtChk_EN <= (state_nxt == START);
      ParChk_EN  <= (state_nxt == PARITY);
      StpChk_EN  <= (state_nxt == STOP);
      Deser_EN   <= deser_nxt;
      Data_Valid <= dv_nxt;
      Frame_Err  <= fe_nxt;
    end
  end

endmodule
